// File: rtl/adc_uart_pkg.sv
// Shared types and constants for the ADC sample UART framer.
package adc_uart_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, MSB, LSB} frame_state_t;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         BITS_PER_BYTE     = 10;

endpackage

// File: rtl/adc_uart_tx_byte.sv
// UART 8N1 byte serialiser; restarts in the done cycle so consecutive bytes have no gap.
module uart_byte_tx
    import adc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done,
    output logic       idle
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(BITS_PER_BYTE - 2);

    byte_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (state != B_IDLE) && (baud_cnt == BAUD_LAST);
    assign done    = (state == B_STOP) && bit_end;
    assign idle    = (state == B_IDLE);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= B_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (start && (idle || done)) begin
            state    <= B_START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= byte_in;
            tx       <= 1'b0;
        end else if (state != B_IDLE) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    B_START: begin
                        state   <= B_DATA;
                        bit_idx <= 4'd1;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                    B_DATA: begin
                        if (bit_idx == LAST_DATA) begin
                            state   <= B_STOP;
                            tx      <= 1'b1;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                        bit_idx <= bit_idx + 4'd1;
                    end
                    default: begin
                        state   <= B_IDLE;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/adc_uart_tx.sv
// Frames accepted 16-bit ADC samples as [sync,] MSB, LSB bytes on a UART line.
module adc_uart_tx
    import adc_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter bit         SEND_SYNC    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        clr_ovr,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    frame_state_t state;
    logic [15:0]  hold;
    logic         accept;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_done;
    logic         byte_idle;

    assign accept = data_valid && data_ready;
    assign busy   = ~data_ready;

    // First byte is chosen from data_in directly because hold only updates at this edge.
    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        case (state)
            IDLE: begin
                byte_start = accept && byte_idle;
                byte_data  = SEND_SYNC ? SYNC_BYTE : data_in[15:8];
            end
            SYNC: begin
                byte_start = byte_done;
                byte_data  = hold[15:8];
            end
            MSB: begin
                byte_start = byte_done;
                byte_data  = hold[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            data_ready <= 1'b1;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    hold       <= data_in;
                    data_ready <= 1'b0;
                    state      <= SEND_SYNC ? SYNC : MSB;
                end
                SYNC: if (byte_done) state <= MSB;
                MSB:  if (byte_done) state <= LSB;
                LSB:  if (byte_done) begin
                    state      <= IDLE;
                    data_ready <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase

            if (data_valid && !data_ready) overrun <= 1'b1;
            else if (clr_ovr)              overrun <= 1'b0;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .start  (byte_start),
        .byte_in(byte_data),
        .tx     (tx),
        .done   (byte_done),
        .idle   (byte_idle)
    );

endmodule

// File: tb/tb_adc_uart_tx.sv
// Self-checking bench: two framers (with and without sync byte) against a timeline model.
module tb_adc_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        clr_ovr = 1'b0;

    logic        tx_s      [2];
    logic        ready_s   [2];
    logic        busy_s    [2];
    logic        ovr_s     [2];
    logic [15:0] cnt_s     [2];

    always #5 clk = ~clk;

    adc_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .SEND_SYNC(1'b1)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_s[0]), .clr_ovr(clr_ovr), .tx(tx_s[0]), .busy(busy_s[0]),
        .overrun(ovr_s[0]), .frame_cnt(cnt_s[0]));

    adc_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .SEND_SYNC(1'b0)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_s[1]), .clr_ovr(clr_ovr), .tx(tx_s[1]), .busy(busy_s[1]),
        .overrun(ovr_s[1]), .frame_cnt(cnt_s[1]));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: a frame is a fixed bit timeline anchored at its acceptance cycle.
    bit          m_sync   [2] = '{1'b1, 1'b0};
    bit          m_active [2];
    int          m_start  [2];
    logic [15:0] m_word   [2];
    bit          m_ovr    [2];
    logic [15:0] m_cnt    [2];

    function automatic int frame_len(int i);
        return (m_sync[i] ? 30 : 20) * CPB;
    endfunction

    function automatic logic exp_tx(int i);
        int off, bit_no, byte_no, pos, word_byte;
        logic [7:0] b;
        if (!m_active[i]) return 1'b1;
        off     = cyc - m_start[i] - 1;
        bit_no  = off / CPB;
        byte_no = bit_no / 10;
        pos     = bit_no % 10;
        word_byte = byte_no - (m_sync[i] ? 1 : 0);
        if (word_byte < 0)       b = 8'hA5;
        else if (word_byte == 0) b = m_word[i][15:8];
        else                     b = m_word[i][7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit clr, input bit r);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (m_active[i] && cyc == m_start[i] + frame_len(i) + 1) begin
                m_active[i] = 1'b0;
                m_cnt[i]    = m_cnt[i] + 16'd1;
            end
            check($sformatf("tx%0d", i),        32'(tx_s[i]),    32'(exp_tx(i)));
            check($sformatf("ready%0d", i),     32'(ready_s[i]), 32'(!m_active[i]));
            check($sformatf("busy%0d", i),      32'(busy_s[i]),  32'(m_active[i]));
            check($sformatf("overrun%0d", i),   32'(ovr_s[i]),   32'(m_ovr[i]));
            check($sformatf("frame_cnt%0d", i), 32'(cnt_s[i]),   32'(m_cnt[i]));
        end
        data_valid = v;
        data_in    = d;
        clr_ovr    = clr;
        rst        = r;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_active[i] = 1'b0;
                m_ovr[i]    = 1'b0;
                m_cnt[i]    = '0;
            end else begin
                if (v && m_active[i])  m_ovr[i] = 1'b1;
                else if (clr)          m_ovr[i] = 1'b0;
                if (v && !m_active[i]) begin
                    m_active[i] = 1'b1;
                    m_start[i]  = cyc;
                    m_word[i]   = d;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic wait_both_idle();
        int k;
        k = 0;
        while ((m_active[0] || m_active[1]) && k < 200) begin
            step(1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        check("idle_timeout", 32'(m_active[0] || m_active[1]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_start[i]  = 0;
            m_word[i]   = '0;
            m_ovr[i]    = 1'b0;
            m_cnt[i]    = '0;
        end
        repeat (2) @(posedge clk);

        // Reset state, then a basic frame: A5,12,34 (dut0) and 12,34 (dut1).
        step(1'b0, '0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        idle(125);

        // Second pattern and overrun: second sample dropped, clear, then set wins over clear.
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        idle(20);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 16'h3333, 1'b1, 1'b0);
        idle(3);
        wait_both_idle();
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Back-to-back: valid held high so each framer re-accepts the cycle it is ready.
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        for (int k = 0; k < 250; k++) step(1'b1, 16'h8000, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        wait_both_idle();

        // Reset during the MSB data bits, then a clean frame.
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        idle(49);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 16'h00FF, 1'b0, 1'b0);
        idle(130);

        // Random traffic.
        for (int k = 0; k < 3000; k++)
            step($urandom_range(19) == 0, 16'($urandom), $urandom_range(29) == 0,
                 $urandom_range(399) == 0);
        wait_both_idle();
        idle(2);

        // Frame counter wrap.
        force dut0.frame_cnt = 16'hFFFF;
        force dut1.frame_cnt = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        m_cnt[1] = 16'hFFFF;
        step(1'b1, 16'h5A3C, 1'b0, 1'b0);
        release dut0.frame_cnt;
        release dut1.frame_cnt;
        idle(130);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
